rst_sync_cnt_bank: RTL and testbench

RST_SYNC_CNT_BANK -- requirements
Module: rst_sync_cnt_bank

---
 rtl/cnt_bank_pkg.sv | 29 ++
 rtl/cnt_bank_lane.sv | 53 +++++
 rtl/rst_release_sync.sv | 36 +++
 rtl/rst_sync_cnt_bank.sv | 75 +++++++
 tb/tb_rst_sync_cnt_bank.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cnt_bank_pkg.sv
// Shared defaults, legality limits and the per-channel request type for the
// reset-synchronised counter bank.
package cnt_bank_pkg;

    localparam int DEF_WIDTH       = 5;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MAX_VAL     = 3;

    localparam int WIDTH_MIN       = 2;
    localparam int WIDTH_MAX       = 16;
    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 16;
    localparam int SYNC_STAGES_MIN = 1;

    typedef struct packed {
        logic en;
        logic clr;
    } lane_req_t;

    function automatic int max_legal_val(input int width);
        return (1 << width) - 1;
    endfunction

    function automatic bit max_val_ok(input int width, input int max_val);
        return (max_val >= 1) && (max_val <= max_legal_val(width));
    endfunction

endpackage

// File: rtl/cnt_bank_lane.sv
// One counter channel: clear beats enable, saturates at MAX_VAL (or wraps when
// CNT_BANK_WRAP_EN is defined), and tracks the registered value minus one.
module cnt_bank_lane
    import cnt_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act,
    input  lane_req_t        req,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_prev,
`ifdef CNT_BANK_WRAP_EN
    output logic             wrap,
`endif
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic at_max;
    assign at_max = (cnt == MAX_V);
    assign sat    = at_max;

    // Nothing moves until the release sequence has completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cnt_prev <= '0;
        end else if (act) begin
            cnt_prev <= cnt - ONE;
            if (req.clr) begin
                cnt <= '0;
            end else if (req.en) begin
                if (!at_max) cnt <= cnt + ONE;
`ifdef CNT_BANK_WRAP_EN
                else         cnt <= '0;
`endif
            end
        end
    end

`ifdef CNT_BANK_WRAP_EN
    always_ff @(posedge clk) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= act & ~req.clr & req.en & at_max;
    end
`endif

endmodule

// File: rtl/rst_release_sync.sv
// Reset-release delay: a chain of ones shifts in once rst drops, and rst_done
// is registered one cycle after the whole chain is full.
module rst_release_sync
    import cnt_bank_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    output logic rst_done
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $fatal(1, "rst_release_sync: SYNC_STAGES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] vld_pipe;

    if (SYNC_STAGES == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (rst) vld_pipe <= '0;
            else     vld_pipe <= 1'b1;
        end
    end else begin : g_shift
        always_ff @(posedge clk) begin
            if (rst) vld_pipe <= '0;
            else     vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= &vld_pipe;
    end

endmodule

// File: rtl/rst_sync_cnt_bank.sv
// Bank of independent saturating counters gated by a reset-release delay.
// Optional build macro CNT_BANK_WRAP_EN: wrap at MAX_VAL and add a wrap pulse.
module rst_sync_cnt_bank
    import cnt_bank_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MAX_VAL     = DEF_MAX_VAL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS*WIDTH-1:0] cnt_prev,
    output logic [CHANNELS-1:0]       sat,
`ifdef CNT_BANK_WRAP_EN
    output logic [CHANNELS-1:0]       wrap,
`endif
    output logic                      all_sat,
    output logic                      rst_done
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "rst_sync_cnt_bank: WIDTH out of range 2..16");
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $fatal(1, "rst_sync_cnt_bank: CHANNELS out of range 1..16");
    end
    if (!max_val_ok(WIDTH, MAX_VAL)) begin : g_bad_max
        $fatal(1, "rst_sync_cnt_bank: MAX_VAL must be 1..2^WIDTH-1");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $fatal(1, "rst_sync_cnt_bank: SYNC_STAGES must be >= 1");
    end

    rst_release_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_release (
        .clk      (clk),
        .rst      (rst),
        .rst_done (rst_done)
    );

    logic [CHANNELS-1:0][WIDTH-1:0] cnt_arr;
    logic [CHANNELS-1:0][WIDTH-1:0] prev_arr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        lane_req_t req;
        assign req = '{en: en[i], clr: clr[i]};

        cnt_bank_lane #(
            .WIDTH   (WIDTH),
            .MAX_VAL (MAX_VAL)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .act      (rst_done),
            .req      (req),
            .cnt      (cnt_arr[i]),
            .cnt_prev (prev_arr[i]),
`ifdef CNT_BANK_WRAP_EN
            .wrap     (wrap[i]),
`endif
            .sat      (sat[i])
        );
    end

    // Packed 2-D arrays flatten with channel i at [i*WIDTH +: WIDTH].
    assign cnt      = cnt_arr;
    assign cnt_prev = prev_arr;
    assign all_sat  = &sat;

endmodule

// File: tb/tb_rst_sync_cnt_bank.sv
// Directed bench for rst_sync_cnt_bank: default 5x2 bank plus an 8-bit 4-channel
// bank saturating at 255.
module tb_rst_sync_cnt_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, all_sat, rst_done;
    logic [1:0] en, clr, sat;
    logic [9:0] cnt, cnt_prev;

    logic        rst2, all_sat2, rst_done2;
    logic [3:0]  en2, clr2, sat2;
    logic [31:0] cnt2, prev2;

`ifdef CNT_BANK_WRAP_EN
    logic [1:0] wrap;
    logic [3:0] wrap2;
`endif

    int checks = 0;
    int failures = 0;
    bit wrap_build;

    rst_sync_cnt_bank dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt(cnt), .cnt_prev(cnt_prev),
        .sat(sat),
`ifdef CNT_BANK_WRAP_EN
        .wrap(wrap),
`endif
        .all_sat(all_sat), .rst_done(rst_done)
    );

    rst_sync_cnt_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .MAX_VAL(255)) dut_wide (
        .clk(clk), .rst(rst2), .en(en2), .clr(clr2), .cnt(cnt2), .cnt_prev(prev2),
        .sat(sat2),
`ifdef CNT_BANK_WRAP_EN
        .wrap(wrap2),
`endif
        .all_sat(all_sat2), .rst_done(rst_done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; clr = '0;
        repeat (3) step();
        checks++; if (rst_done !== 1'b0) begin failures++; $display("FAIL reset_rst_done got=%b exp=0", rst_done); end
        checks++; if (cnt !== 10'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
        checks++; if (cnt_prev !== 10'd0) begin failures++; $display("FAIL reset_cnt_prev got=%h exp=0", cnt_prev); end
        checks++; if (sat !== 2'b00) begin failures++; $display("FAIL reset_sat got=%b exp=00", sat); end
        checks++; if (all_sat !== 1'b0) begin failures++; $display("FAIL reset_all_sat got=%b exp=0", all_sat); end
    endtask

    task automatic test_release();
        int exp_c[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
        bit exp_rd[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        en = 2'b11; rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (rst_done !== exp_rd[k]) begin failures++; $display("FAIL release_rd[%0d] got=%b exp=%b", k, rst_done, exp_rd[k]); end
            checks++; if (cnt !== {5'(exp_c[k]), 5'(exp_c[k])}) begin failures++; $display("FAIL release_cnt[%0d] got=%h exp=%0d/%0d", k, cnt, exp_c[k], exp_c[k]); end
        end
        checks++; if (all_sat !== 1'b1) begin failures++; $display("FAIL release_all_sat got=%b exp=1", all_sat); end
    endtask

    task automatic test_sat_prev();
        int exp_c[5] = '{1, 2, 3, 3, 3};
        int exp_p[5] = '{31, 0, 1, 2, 2};
        int exp_c1[3] = '{1, 2, 3};
        bit exp_as[3] = '{0, 0, 1};
        en = 2'b00; clr = 2'b11;
        step();
        checks++; if (cnt !== 10'd0) begin failures++; $display("FAIL satprev_clr_cnt got=%h exp=0", cnt); end
        checks++; if (cnt_prev !== {5'd2, 5'd2}) begin failures++; $display("FAIL satprev_clr_prev got=%h exp=2/2", cnt_prev); end
        clr = 2'b00; en = 2'b01;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (cnt[4:0] !== 5'(exp_c[k])) begin failures++; $display("FAIL satprev_cnt0[%0d] got=%0d exp=%0d", k, cnt[4:0], exp_c[k]); end
            checks++; if (cnt_prev[4:0] !== 5'(exp_p[k])) begin failures++; $display("FAIL satprev_prev0[%0d] got=%0d exp=%0d", k, cnt_prev[4:0], exp_p[k]); end
            checks++; if (sat[0] !== (exp_c[k] == 3)) begin failures++; $display("FAIL satprev_sat0[%0d] got=%b exp=%b", k, sat[0], exp_c[k] == 3); end
            checks++; if (cnt[9:5] !== 5'd0 || all_sat !== 1'b0) begin failures++; $display("FAIL satprev_ch1_idle[%0d] got=%0d/%b exp=0/0", k, cnt[9:5], all_sat); end
        end
        en = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (cnt[9:5] !== 5'(exp_c1[k])) begin failures++; $display("FAIL satprev_cnt1[%0d] got=%0d exp=%0d", k, cnt[9:5], exp_c1[k]); end
            checks++; if (all_sat !== exp_as[k]) begin failures++; $display("FAIL satprev_all_sat[%0d] got=%b exp=%b", k, all_sat, exp_as[k]); end
            checks++; if (cnt[4:0] !== 5'd3) begin failures++; $display("FAIL satprev_ch0_hold[%0d] got=%0d exp=3", k, cnt[4:0]); end
        end
        en = 2'b00;
    endtask

    task automatic test_clr_priority();
        clr = 2'b10; en = 2'b00;
        step();
        clr = 2'b00; en = 2'b10;
        step(); step();
        checks++; if (cnt !== {5'd2, 5'd3}) begin failures++; $display("FAIL clrpri_setup got=%h exp=2/3", cnt); end
        clr = 2'b10; en = 2'b10;
        step();
        checks++; if (cnt[9:5] !== 5'd0) begin failures++; $display("FAIL clrpri_ch1 got=%0d exp=0", cnt[9:5]); end
        checks++; if (cnt[4:0] !== 5'd3) begin failures++; $display("FAIL clrpri_ch0 got=%0d exp=3", cnt[4:0]); end
        clr = 2'b00; en = 2'b00;
    endtask

    task automatic test_mid_reset();
        int exp_c[4] = '{0, 0, 0, 1};
        bit exp_rd[4] = '{0, 0, 1, 1};
        clr = 2'b11;
        step();
        clr = 2'b00; en = 2'b01;
        step(); step();
        checks++; if (cnt[4:0] !== 5'd2) begin failures++; $display("FAIL midrst_setup got=%0d exp=2", cnt[4:0]); end
        rst = 1'b1;
        step();
        checks++; if (cnt !== 10'd0 || cnt_prev !== 10'd0) begin failures++; $display("FAIL midrst_cnt got=%h/%h exp=0/0", cnt, cnt_prev); end
        checks++; if (sat !== 2'b00 || all_sat !== 1'b0 || rst_done !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b/%b/%b exp=00/0/0", sat, all_sat, rst_done); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rst_done !== exp_rd[k]) begin failures++; $display("FAIL midrst_rd[%0d] got=%b exp=%b", k, rst_done, exp_rd[k]); end
            checks++; if (cnt[4:0] !== 5'(exp_c[k])) begin failures++; $display("FAIL midrst_cnt0[%0d] got=%0d exp=%0d", k, cnt[4:0], exp_c[k]); end
        end
    endtask

`ifdef CNT_BANK_WRAP_EN
    task automatic test_wrap();
        en = 2'b01;
        step(); step();
        checks++; if (cnt[4:0] !== 5'd3 || wrap !== 2'b00) begin failures++; $display("FAIL wrap_setup got=%0d/%b exp=3/00", cnt[4:0], wrap); end
        step();
        checks++; if (cnt[4:0] !== 5'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", cnt[4:0]); end
        checks++; if (wrap !== 2'b01) begin failures++; $display("FAIL wrap_pulse got=%b exp=01", wrap); end
        en = 2'b00;
        step();
        checks++; if (wrap !== 2'b00 || cnt[4:0] !== 5'd0) begin failures++; $display("FAIL wrap_single got=%b/%0d exp=00/0", wrap, cnt[4:0]); end
    endtask
`else
    task automatic test_sat_hold();
        en = 2'b01;
        step(); step();
        checks++; if (cnt[4:0] !== 5'd3 || sat[0] !== 1'b1) begin failures++; $display("FAIL hold_reach got=%0d/%b exp=3/1", cnt[4:0], sat[0]); end
        step();
        checks++; if (cnt[4:0] !== 5'd3) begin failures++; $display("FAIL hold_en got=%0d exp=3", cnt[4:0]); end
        en = 2'b00;
        step();
        checks++; if (cnt[4:0] !== 5'd3 || cnt_prev[4:0] !== 5'd2) begin failures++; $display("FAIL hold_idle got=%0d/%0d exp=3/2", cnt[4:0], cnt_prev[4:0]); end
    endtask
`endif

    task automatic test_wide();
        logic [7:0] ch0_after;
        ch0_after = wrap_build ? 8'd0 : 8'd255;
        rst2 = 1'b0;
        step(); step();
        checks++; if (rst_done2 !== 1'b0) begin failures++; $display("FAIL wide_rd_early got=%b exp=0", rst_done2); end
        step();
        checks++; if (rst_done2 !== 1'b1) begin failures++; $display("FAIL wide_rd got=%b exp=1", rst_done2); end
        en2 = 4'b0101;
        repeat (254) step();
        checks++; if (cnt2 !== {8'd0, 8'd254, 8'd0, 8'd254} || sat2 !== 4'b0000) begin failures++; $display("FAIL wide_254 got=%h/%b exp=00fe00fe/0000", cnt2, sat2); end
        step();
        checks++; if (cnt2 !== {8'd0, 8'd255, 8'd0, 8'd255}) begin failures++; $display("FAIL wide_255 got=%h exp=00ff00ff", cnt2); end
        checks++; if (sat2 !== 4'b0101 || all_sat2 !== 1'b0) begin failures++; $display("FAIL wide_sat got=%b/%b exp=0101/0", sat2, all_sat2); end
        step();
        checks++; if (cnt2[7:0] !== ch0_after || cnt2[23:16] !== ch0_after) begin failures++; $display("FAIL wide_hold got=%h exp=%0d", cnt2, ch0_after); end
        checks++; if (prev2[7:0] !== 8'd254 || prev2[23:16] !== 8'd254) begin failures++; $display("FAIL wide_prev got=%h exp=254 on ch0/ch2", prev2); end
        en2 = 4'b1010;
        repeat (255) step();
        checks++; if (cnt2[15:8] !== 8'd255 || cnt2[31:24] !== 8'd255) begin failures++; $display("FAIL wide_odd got=%h exp=ff on ch1/ch3", cnt2); end
        checks++; if (all_sat2 !== !wrap_build) begin failures++; $display("FAIL wide_all_sat got=%b exp=%b", all_sat2, !wrap_build); end
        en2 = 4'b0000;
        step();
        checks++; if (prev2[15:8] !== 8'd254 || prev2[31:24] !== 8'd254) begin failures++; $display("FAIL wide_prev_odd got=%h exp=254 on ch1/ch3", prev2); end
    endtask

    initial begin
`ifdef CNT_BANK_WRAP_EN
        wrap_build = 1'b1;
`else
        wrap_build = 1'b0;
`endif
        rst = 1'b1; en = '0; clr = '0;
        rst2 = 1'b1; en2 = '0; clr2 = '0;
        test_reset();
        test_release();
        test_sat_prev();
        test_clr_priority();
        test_mid_reset();
`ifdef CNT_BANK_WRAP_EN
        test_wrap();
`else
        test_sat_hold();
`endif
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
